// File: rtl/pwm_sine_cmd_ctrl.sv
// UART command controller for the PWM sine generator.
// Parses SYNC/CMD/DH/DL/CHK frames from the UART receiver, updates the generator
// configuration (phase increment, amplitude, enable) and answers with ACK, NAK or a
// two-byte status reply over a valid/ready byte interface.
module pwm_sine_cmd_ctrl #(
    parameter logic [15:0] FREQ_RST    = 16'h0100,
    parameter logic [7:0]  AMP_RST     = 8'hFF,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] freq_word,
    output logic [7:0]  amplitude,
    output logic        gen_en,
    output logic        cfg_update,
    output logic [7:0]  err_count
);

    // Counter must be able to hold TIMEOUT_CYC itself.
    localparam int unsigned    CntW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CmdFreq   = 8'h01;
    localparam logic [7:0] CmdAmp    = 8'h02;
    localparam logic [7:0] CmdEnable = 8'h03;
    localparam logic [7:0] CmdStatus = 8'h04;
    localparam logic [7:0] ByteAck   = 8'h06;
    localparam logic [7:0] ByteNak   = 8'h15;

    typedef enum logic [3:0] {
        StIdle,
        StGetCmd,
        StGetDh,
        StGetDl,
        StGetChk,
        StExec,
        StTxAck,
        StTxHi,
        StTxLo,
        StTxNak
    } state_e;

    state_e          r_state;
    state_e          w_state_d;

    logic [CntW-1:0] r_cnt;
    logic [7:0]      r_cmd;
    logic [7:0]      r_dh;
    logic [7:0]      r_dl;
    logic [7:0]      r_chk;

    logic [15:0]     r_freq;
    logic [7:0]      r_amp;
    logic            r_gen_en;
    logic            r_cfg_update;
    logic [7:0]      r_err_count;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;

    logic            w_in_get;
    logic            w_timeout;
    logic            w_tx_fire;
    logic            w_chk_ok;
    logic            w_cmd_known;
    logic            w_exec_ok;

    logic            w_freq_we;
    logic            w_amp_we;
    logic            w_en_we;
    logic            w_err_inc;
    logic            w_tx_valid_d;
    logic [7:0]      w_tx_byte;

    assign w_in_get    = (r_state == StGetCmd) || (r_state == StGetDh) ||
                         (r_state == StGetDl)  || (r_state == StGetChk);
    // A byte arriving on the last allowed cycle still wins over the timeout.
    assign w_timeout   = w_in_get && !rx_valid && (r_cnt == CntMax);
    assign w_tx_fire   = r_tx_valid && tx_ready;
    assign w_chk_ok    = (r_chk == (r_cmd ^ r_dh ^ r_dl));
    assign w_cmd_known = (r_cmd == CmdFreq) || (r_cmd == CmdAmp) ||
                         (r_cmd == CmdEnable) || (r_cmd == CmdStatus);
    assign w_exec_ok   = w_chk_ok && w_cmd_known;

    // State register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; bytes arriving in EXEC or TX states are simply not looked at.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_d = StGetCmd;
                end
            end
            StGetCmd: begin
                if (rx_valid) begin
                    w_state_d = StGetDh;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            StGetDh: begin
                if (rx_valid) begin
                    w_state_d = StGetDl;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            StGetDl: begin
                if (rx_valid) begin
                    w_state_d = StGetChk;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            StGetChk: begin
                if (rx_valid) begin
                    w_state_d = StExec;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            StExec: begin
                w_state_d = w_exec_ok ? StTxAck : StTxNak;
            end
            StTxAck: begin
                if (w_tx_fire) begin
                    w_state_d = (r_cmd == CmdStatus) ? StTxHi : StIdle;
                end
            end
            StTxHi: begin
                if (w_tx_fire) begin
                    w_state_d = StTxLo;
                end
            end
            StTxLo: begin
                if (w_tx_fire) begin
                    w_state_d = StIdle;
                end
            end
            StTxNak: begin
                if (w_tx_fire) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output decode: register write enables and the next TX byte/valid.
    // tx_valid drops for one cycle after every accepted byte, and rises while the
    // FSM is heading into (or waiting in) a TX state.
    always_comb begin
        w_freq_we    = 1'b0;
        w_amp_we     = 1'b0;
        w_en_we      = 1'b0;
        w_err_inc    = 1'b0;
        w_tx_byte    = 8'h00;
        w_tx_valid_d = 1'b0;

        if (r_state == StExec) begin
            w_freq_we = w_exec_ok && (r_cmd == CmdFreq);
            w_amp_we  = w_exec_ok && (r_cmd == CmdAmp);
            w_en_we   = w_exec_ok && (r_cmd == CmdEnable);
            w_err_inc = !w_exec_ok;
        end

        case (w_state_d)
            StTxAck: w_tx_byte = ByteAck;
            StTxHi:  w_tx_byte = r_freq[15:8];
            StTxLo:  w_tx_byte = r_freq[7:0];
            StTxNak: w_tx_byte = ByteNak;
            default: w_tx_byte = 8'h00;
        endcase

        if ((w_state_d == StTxAck) || (w_state_d == StTxHi) ||
            (w_state_d == StTxLo) || (w_state_d == StTxNak)) begin
            w_tx_valid_d = !w_tx_fire;
        end
    end

    // Inter-byte timeout counter, only running while a frame is being received.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_in_get && !rx_valid) begin
            r_cnt <= r_cnt + CntW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Frame field capture.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_cmd <= 8'h00;
            r_dh  <= 8'h00;
            r_dl  <= 8'h00;
            r_chk <= 8'h00;
        end else if (rx_valid) begin
            case (r_state)
                StGetCmd: r_cmd <= rx_data;
                StGetDh:  r_dh  <= rx_data;
                StGetDl:  r_dl  <= rx_data;
                StGetChk: r_chk <= rx_data;
                default:  ;
            endcase
        end
    end

    // Configuration registers; cfg_update rises on the same edge as the write.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_freq       <= FREQ_RST;
            r_amp        <= AMP_RST;
            r_gen_en     <= 1'b0;
            r_cfg_update <= 1'b0;
        end else begin
            if (w_freq_we) begin
                r_freq <= {r_dh, r_dl};
            end
            if (w_amp_we) begin
                r_amp <= r_dl;
            end
            if (w_en_we) begin
                r_gen_en <= r_dl[0];
            end
            r_cfg_update <= w_freq_we || w_amp_we || w_en_we;
        end
    end

    // Saturating count of NAKed frames.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_err_count <= 8'h00;
        end else if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    // TX byte register; data only reloads while valid is (re)asserted so it is
    // stable during a stall.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_valid <= w_tx_valid_d;
            if (w_tx_valid_d) begin
                r_tx_data <= w_tx_byte;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign freq_word  = r_freq;
    assign amplitude  = r_amp;
    assign gen_en     = r_gen_en;
    assign cfg_update = r_cfg_update;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_pwm_sine_cmd_ctrl.sv
// Self-checking bench for pwm_sine_cmd_ctrl: expected TX bytes are queued when a
// frame is driven and compared as the DUT hands them off.
module tb_pwm_sine_cmd_ctrl;

    logic        clk1     = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] freq_word;
    logic [7:0]  amplitude;
    logic        gen_en;
    logic        cfg_update;
    logic [7:0]  err_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          cfg_cnt  = 0;
    logic [15:0] cfg_freq_snap = 16'h0000;
    logic        prev_fire = 1'b0;
    int          c0;

    pwm_sine_cmd_ctrl #(
        .FREQ_RST    (16'h0100),
        .AMP_RST     (8'hFF),
        .TIMEOUT_CYC (20),
        .SYNC_BYTE   (8'hA5)
    ) u_dut (
        .clk1       (clk1),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .freq_word  (freq_word),
        .amplitude  (amplitude),
        .gen_en     (gen_en),
        .cfg_update (cfg_update),
        .err_count  (err_count)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes, post-handshake gap and cfg_update pulses, mid-cycle.
    always @(negedge clk1) begin
        if (prev_fire) begin
            check("tx_gap", {31'd0, tx_valid}, 32'd0);
        end
        if (cfg_update) begin
            cfg_cnt++;
            cfg_freq_snap = freq_word;
        end
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            prev_fire = 1'b1;
        end else begin
            prev_fire = 1'b0;
        end
    end

    // All bench inputs change 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk1);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(dh);
        send_byte(dl);
        send_byte(chk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 50; k++) begin
            if (tx_valid) break;
            @(posedge clk1);
            #1;
        end
        if (k == 50) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk1);
            #1;
            if (exp_q.size() == 0 && !tx_valid) break;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset values
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk1);
        check("rst_freq", {16'd0, freq_word}, 32'h0100);
        check("rst_amp", {24'd0, amplitude}, 32'hFF);
        check("rst_gen_en", {31'd0, gen_en}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_cfg_update", {31'd0, cfg_update}, 32'd0);
        @(posedge clk1);
        #1;

        // 2: set frequency, CHK = 01^12^34 = 27
        tx_ready = 1'b1;
        c0 = cfg_cnt;
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27);
        drain();
        check("t2_freq", {16'd0, freq_word}, 32'h1234);
        check("t2_cfg_pulses", cfg_cnt - c0, 32'd1);
        check("t2_cfg_with_value", {16'd0, cfg_freq_snap}, 32'h1234);

        // 3: status request with a stalled transmitter
        tx_ready = 1'b0;
        c0 = cfg_cnt;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h04, 8'h00, 8'h00, 8'h04);
        wait_valid();
        repeat (5) begin
            check("t3_stall_data", {24'd0, tx_data}, 32'h06);
            check("t3_stall_valid", {31'd0, tx_valid}, 32'd1);
            idle(1);
        end
        tx_ready = 1'b1;
        drain();
        check("t3_cfg_pulses", cfg_cnt - c0, 32'd0);
        check("t3_freq", {16'd0, freq_word}, 32'h1234);

        // 4: bad checksum, then enable
        exp_q.push_back(8'h15);
        send_frame(8'h02, 8'h00, 8'h80, 8'hFF);
        drain();
        check("t4_amp", {24'd0, amplitude}, 32'hFF);
        check("t4_err", {24'd0, err_count}, 32'd1);
        exp_q.push_back(8'h06);
        send_frame(8'h03, 8'h00, 8'h01, 8'h02);
        drain();
        check("t4_gen_en", {31'd0, gen_en}, 32'd1);
        check("t4_err_hold", {24'd0, err_count}, 32'd1);

        // 5: inter-byte timeout drops the frame silently
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hAB);
        idle(25);
        check("t5_no_tx", {31'd0, tx_valid}, 32'd0);
        exp_q.push_back(8'h06);
        send_frame(8'h02, 8'h00, 8'h40, 8'h42);
        drain();
        check("t5_amp", {24'd0, amplitude}, 32'h40);
        check("t5_err", {24'd0, err_count}, 32'd1);
        check("t5_freq", {16'd0, freq_word}, 32'h1234);

        // 6: reset during the high status byte
        tx_ready = 1'b0;
        exp_q.push_back(8'h06);
        send_frame(8'h04, 8'h00, 8'h00, 8'h04);
        wait_valid();
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        idle(1);
        wait_valid();
        check("t6_hi_byte", {24'd0, tx_data}, 32'h12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk1);
        check("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_freq", {16'd0, freq_word}, 32'h0100);
        check("t6_amp", {24'd0, amplitude}, 32'hFF);
        check("t6_gen_en", {31'd0, gen_en}, 32'd0);
        check("t6_err", {24'd0, err_count}, 32'd0);
        @(posedge clk1);
        #1;
        tx_ready = 1'b1;
        idle(10);
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h56, 8'h78, 8'h2F);
        drain();
        check("t6_new_freq", {16'd0, freq_word}, 32'h5678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
